stream_unpacker: RTL and testbench

- Single-clock consumer of the tagged 16-bit sample stream that the rx FIFO path produces: a 16'h4000 tag word, then channel-interleaved samples ch0..ch(N-1), repeated.
- Reads words from a normal-mode (non-show-ahead) FIFO read port and reassembles them into parallel per-channel sample sets.
- Presents each complete set on dout0..dout7 with a valid/ready handshake and flags the first set after each tag.
- Used on the loopback/verification path and as the tx-side deframer ahead of the DAC interface.

---
 rtl/stream_unpacker.sv | 156 +++++++++++++++
 tb/tb_stream_unpacker.sv | 468 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_unpacker.sv
// Reassembles a tagged, channel-interleaved 16-bit word stream read from a
// normal-mode FIFO into parallel per-channel sample sets with a valid/ready output.
module stream_unpacker #(
  parameter logic [15:0] TAG_WORD = 16'h4000,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [3:0]       channels,
  input  logic             clear_status,
  input  logic             fifo_empty,
  input  logic [15:0]      fifo_q,
  output logic             fifo_rdreq,
  output logic [15:0]      dout0,
  output logic [15:0]      dout1,
  output logic [15:0]      dout2,
  output logic [15:0]      dout3,
  output logic [15:0]      dout4,
  output logic [15:0]      dout5,
  output logic [15:0]      dout6,
  output logic [15:0]      dout7,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             gate_start,
  output logic             sync_error,
  output logic [CNT_W-1:0] set_count
);

  localparam int unsigned W   = 16;
  localparam int unsigned NCH = 8;

  typedef enum logic {HUNT, RUN} state_t;

  state_t           state, state_nxt;
  logic [2:0]       idx, idx_nxt;
  logic [3:0]       nch, nch_nxt;
  logic             pend, pend_nxt;
  logic             in_flight;
  logic [W-1:0]     shadow [NCH];
  logic [W-1:0]     shadow_nxt [NCH];
  logic [W-1:0]     dout_r [NCH];
  logic [W-1:0]     dout_nxt [NCH];
  logic             out_valid_nxt, gate_start_nxt, sync_error_nxt;
  logic [CNT_W-1:0] set_count_nxt;
  logic [3:0]       ch_clamped;
  logic             is_tag, last, complete;

  // Channel count latched on a HUNT tag: 0 behaves as 1, anything above 8 as 8.
  always_comb begin
    if (channels == 4'd0)      ch_clamped = 4'd1;
    else if (channels > 4'd8)  ch_clamped = 4'd8;
    else                       ch_clamped = channels;
  end

  assign is_tag   = (fifo_q == TAG_WORD);
  assign last     = ({1'b0, idx} == (nch - 4'd1));
  assign complete = in_flight && (state == RUN) && !((idx == 3'd0) && is_tag) && last;

  // Holding off the read while the returning word closes a set keeps the output slot free.
  assign fifo_rdreq = !reset && enable && !fifo_empty && !(out_valid && !out_ready) && !complete;

  always_comb begin
    state_nxt      = state;
    idx_nxt        = idx;
    nch_nxt        = nch;
    pend_nxt       = pend;
    shadow_nxt     = shadow;
    dout_nxt       = dout_r;
    out_valid_nxt  = out_valid;
    gate_start_nxt = gate_start;
    sync_error_nxt = sync_error;
    set_count_nxt  = set_count;

    if (out_valid && out_ready) out_valid_nxt = 1'b0;
    if (clear_status)           sync_error_nxt = 1'b0;

    case (state)
      HUNT: begin
        if (in_flight && is_tag && enable) begin
          state_nxt = RUN;
          nch_nxt   = ch_clamped;
          idx_nxt   = 3'd0;
          pend_nxt  = 1'b1;
        end
      end
      RUN: begin
        if (in_flight) begin
          if ((idx == 3'd0) && is_tag) begin
            pend_nxt = 1'b1;
          end else begin
            shadow_nxt[idx] = fifo_q;
            if (last) begin
              for (int i = 0; i < NCH; i++)
                dout_nxt[i] = (4'(i) < nch) ? shadow[i] : '0;
              dout_nxt[idx]  = fifo_q;
              out_valid_nxt  = 1'b1;
              gate_start_nxt = pend;
              pend_nxt       = 1'b0;
              idx_nxt        = 3'd0;
              set_count_nxt  = set_count + CNT_W'(1);
            end else begin
              idx_nxt = idx + 3'd1;
            end
          end
        end
        // Dropping enable mid-set throws the partial set away and flags it.
        if (!enable) begin
          state_nxt = HUNT;
          if (idx_nxt != 3'd0) sync_error_nxt = 1'b1;
          idx_nxt  = 3'd0;
          pend_nxt = 1'b0;
        end
      end
      default: state_nxt = HUNT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= HUNT;
      idx        <= 3'd0;
      nch        <= 4'd1;
      pend       <= 1'b0;
      in_flight  <= 1'b0;
      shadow     <= '{default: '0};
      dout_r     <= '{default: '0};
      out_valid  <= 1'b0;
      gate_start <= 1'b0;
      sync_error <= 1'b0;
      set_count  <= '0;
    end else begin
      state      <= state_nxt;
      idx        <= idx_nxt;
      nch        <= nch_nxt;
      pend       <= pend_nxt;
      in_flight  <= fifo_rdreq;
      shadow     <= shadow_nxt;
      dout_r     <= dout_nxt;
      out_valid  <= out_valid_nxt;
      gate_start <= gate_start_nxt;
      sync_error <= sync_error_nxt;
      set_count  <= set_count_nxt;
    end
  end

  assign dout0 = dout_r[0];
  assign dout1 = dout_r[1];
  assign dout2 = dout_r[2];
  assign dout3 = dout_r[3];
  assign dout4 = dout_r[4];
  assign dout5 = dout_r[5];
  assign dout6 = dout_r[6];
  assign dout7 = dout_r[7];

endmodule

// File: tb/tb_stream_unpacker.sv
// Self-checking bench for stream_unpacker: a latency-1 FIFO model feeds the DUT and
// accepted sets are compared with a word-level reference of the tagged stream format.
module tb_stream_unpacker;

  localparam logic [15:0] TAG   = 16'h4000;
  localparam int          DEPTH = 1024;

  typedef struct packed {
    logic             gs;
    logic [7:0][15:0] d;
  } set_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [3:0]  channels = 4'd1;
  logic        clear_status = 1'b0;
  logic        fifo_empty;
  logic [15:0] fifo_q = '0;
  logic        fifo_rdreq;
  logic [15:0] dout [8];
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        gate_start;
  logic        sync_error;
  logic [15:0] set_count;

  int asserts = 0;
  int fails = 0;
  int exp_total = 0;

  always #5 clk = ~clk;

  stream_unpacker dut (
    .clk(clk), .reset(reset), .enable(enable), .channels(channels),
    .clear_status(clear_status), .fifo_empty(fifo_empty), .fifo_q(fifo_q),
    .fifo_rdreq(fifo_rdreq),
    .dout0(dout[0]), .dout1(dout[1]), .dout2(dout[2]), .dout3(dout[3]),
    .dout4(dout[4]), .dout5(dout[5]), .dout6(dout[6]), .dout7(dout[7]),
    .out_valid(out_valid), .out_ready(out_ready), .gate_start(gate_start),
    .sync_error(sync_error), .set_count(set_count)
  );

  // FIFO model: the stimulus side only advances wr_ptr, the read port only rd_ptr.
  logic [15:0] mem [DEPTH];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (fifo_rdreq && (wr_ptr != rd_ptr)) begin
      fifo_q <= mem[rd_ptr % DEPTH];
      rd_ptr <= rd_ptr + 1;
    end
  end

  // Output monitor: records accepted sets and checks dout holds still under backpressure.
  int   cyc = 0;
  set_t got [DEPTH];
  int   got_cyc [DEPTH];
  int   got_cnt = 0;
  int   stab_viol = 0;
  logic hold_prev = 1'b0;
  set_t prev_set = '0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin : mon
    set_t cur;
    cur.gs = gate_start;
    for (int i = 0; i < 8; i++) cur.d[i] = dout[i];
    if (!reset && hold_prev && (cur !== prev_set)) stab_viol <= stab_viol + 1;
    if (!reset && out_valid && out_ready) begin
      got[got_cnt % DEPTH]     <= cur;
      got_cyc[got_cnt % DEPTH] <= cyc;
      got_cnt                  <= got_cnt + 1;
    end
    hold_prev <= !reset && out_valid && !out_ready;
    prev_set  <= cur;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] w);
    mem[wr_ptr % DEPTH] = w;
    wr_ptr = wr_ptr + 1;
  endtask

  // Runs until the FIFO is empty and the output slot has drained; channels is scrambled
  // early on, which must not matter once the first tag has been taken.
  task automatic drain(input int ready_pct, output bit ok);
    ok = 1'b0;
    for (int it = 0; it < 3000 && !ok; it++) begin
      if (it == 12) channels = 4'($urandom_range(15));
      if (rd_ptr == wr_ptr) begin
        out_ready = 1'b1;
        tick(3);
        ok = !out_valid;
      end else begin
        out_ready = ($urandom_range(99) < ready_pct);
        tick(1);
      end
    end
  endtask

  // Reference: walks the word stream by the format rules and lists the sets it implies.
  task automatic model(input int ch, input logic [15:0] w[$], output set_t exp[$],
                       output bit partial);
    int          n;
    bit          hunting;
    bit          gs;
    logic [15:0] samp[$];
    set_t        s;
    n = (ch == 0) ? 1 : (ch > 8) ? 8 : ch;
    hunting = 1'b1;
    gs = 1'b0;
    exp.delete();
    foreach (w[k]) begin
      if (hunting) begin
        if (w[k] == TAG) begin
          hunting = 1'b0;
          gs = 1'b1;
        end
      end else if (samp.size() == 0 && w[k] == TAG) begin
        gs = 1'b1;
      end else begin
        samp.push_back(w[k]);
        if (samp.size() == n) begin
          s = '0;
          s.gs = gs;
          for (int i = 0; i < n; i++) s.d[i] = samp[i];
          exp.push_back(s);
          gs = 1'b0;
          samp.delete();
        end
      end
    end
    partial = !hunting && (samp.size() != 0);
  endtask

  task automatic test_stream(input string name, input int ch, input logic [15:0] w[$],
                             input int ready_pct, output int base);
    set_t exp[$];
    bit   partial;
    bit   ok;
    model(ch, w, exp, partial);
    base = got_cnt;
    foreach (w[k]) push(w[k]);
    channels = 4'(ch);
    enable = 1'b1;
    drain(ready_pct, ok);
    enable = 1'b0;
    tick(2);
    asserts++;
    if (!ok) begin
      fails++;
      $display("FAIL %s_drain: stream did not drain within the cycle budget", name);
    end
    asserts++;
    if (got_cnt - base != exp.size()) begin
      fails++;
      $display("FAIL %s_count: got %0d sets, want %0d", name, got_cnt - base, exp.size());
    end
    for (int i = 0; i < exp.size() && i < got_cnt - base; i++) begin
      asserts++;
      if (got[(base + i) % DEPTH] !== exp[i]) begin
        fails++;
        $display("FAIL %s_set%0d: got %h want %h", name, i, got[(base + i) % DEPTH], exp[i]);
      end
    end
    exp_total += exp.size();
    asserts++;
    if (set_count !== 16'(exp_total)) begin
      fails++;
      $display("FAIL %s_set_count: got %0d want %0d", name, set_count, 16'(exp_total));
    end
    asserts++;
    if (sync_error !== partial) begin
      fails++;
      $display("FAIL %s_sync_error: got %b want %b", name, sync_error, partial);
    end
    clear_status = 1'b1;
    tick(1);
    clear_status = 1'b0;
    asserts++;
    if (sync_error !== 1'b0) begin
      fails++;
      $display("FAIL %s_clear: sync_error got %b want 0", name, sync_error);
    end
  endtask

  task automatic test_reset();
    tick(2);
    asserts++;
    if ({out_valid, fifo_rdreq, gate_start, sync_error} !== 4'b0 || set_count !== 16'd0) begin
      fails++;
      $display("FAIL reset_ctl: got v=%b rd=%b gs=%b err=%b cnt=%0d want all 0",
               out_valid, fifo_rdreq, gate_start, sync_error, set_count);
    end
    for (int i = 0; i < 8; i++) begin
      asserts++;
      if (dout[i] !== 16'h0) begin
        fails++;
        $display("FAIL reset_dout%0d: got %h want 0000", i, dout[i]);
      end
    end
    reset = 1'b0;
    tick(2);
    asserts++;
    if (out_valid !== 1'b0 || set_count !== 16'd0) begin
      fails++;
      $display("FAIL reset_release: got v=%b cnt=%0d want 0/0", out_valid, set_count);
    end
  endtask

  task automatic test_basic();
    logic [15:0] v [9] = '{16'h4000, 16'h0011, 16'h0022, 16'h0033, 16'h0044,
                           16'h0055, 16'h0066, 16'h0077, 16'h0088};
    logic [15:0] w [$];
    int b;
    foreach (v[k]) w.push_back(v[k]);
    test_stream("basic", 4, w, 100, b);
    asserts++;
    if (got[b].d !== {64'h0, 64'h0044_0033_0022_0011} || got[b].gs !== 1'b1) begin
      fails++;
      $display("FAIL basic_first: got %h want gs=1 0044_0033_0022_0011", got[b]);
    end
    asserts++;
    if (got[b + 1].d !== {64'h0, 64'h0088_0077_0066_0055} || got[b + 1].gs !== 1'b0) begin
      fails++;
      $display("FAIL basic_second: got %h want gs=0 0088_0077_0066_0055", got[b + 1]);
    end
    asserts++;
    if (set_count !== 16'd2) begin
      fails++;
      $display("FAIL basic_set_count: got %0d want 2", set_count);
    end
  endtask

  task automatic test_hunt_junk();
    logic [15:0] v [11] = '{16'h1234, 16'h5678, 16'h4000, 16'h0011, 16'h0022, 16'h0033,
                            16'h0044, 16'h0055, 16'h0066, 16'h0077, 16'h0088};
    logic [15:0] w [$];
    int b;
    foreach (v[k]) w.push_back(v[k]);
    test_stream("hunt_junk", 4, w, 70, b);
    asserts++;
    if (got[b].d !== {64'h0, 64'h0044_0033_0022_0011} || got[b].gs !== 1'b1) begin
      fails++;
      $display("FAIL hunt_junk_first: got %h want gs=1 0044_0033_0022_0011", got[b]);
    end
  endtask

  task automatic test_tag_as_data();
    logic [15:0] v [5] = '{16'h4000, 16'h4000, 16'h0001, 16'h4000, 16'h0002};
    logic [15:0] w [$];
    int b;
    foreach (v[k]) w.push_back(v[k]);
    test_stream("tag_as_data", 3, w, 100, b);
    asserts++;
    if (got[b].d !== {80'h0, 48'h0002_4000_0001} || got[b].gs !== 1'b1) begin
      fails++;
      $display("FAIL tag_as_data_set: got %h want gs=1 0002_4000_0001", got[b]);
    end
  endtask

  task automatic test_backpressure();
    int base;
    int sv0;
    bit ok;
    base = got_cnt;
    push(TAG);
    for (int k = 0; k < 16; k++) push(16'(16'h0100 + k));
    channels = 4'd1;
    out_ready = 1'b0;
    enable = 1'b1;
    for (int k = 0; k < 50 && !out_valid; k++) tick(1);
    asserts++;
    if (out_valid !== 1'b1) begin
      fails++;
      $display("FAIL bp_first_valid: out_valid got %b want 1", out_valid);
    end
    sv0 = stab_viol;
    for (int k = 0; k < 10; k++) begin
      tick(1);
      asserts++;
      if (fifo_rdreq !== 1'b0 || out_valid !== 1'b1 || dout[0] !== 16'h0100) begin
        fails++;
        $display("FAIL bp_stall%0d: got rd=%b v=%b d0=%h want 0/1/0100",
                 k, fifo_rdreq, out_valid, dout[0]);
      end
    end
    drain(100, ok);
    enable = 1'b0;
    tick(2);
    asserts++;
    if (!ok || got_cnt - base != 16) begin
      fails++;
      $display("FAIL bp_count: got %0d sets (drained=%b) want 16", got_cnt - base, ok);
    end
    for (int i = 0; i < 16 && i < got_cnt - base; i++) begin
      asserts++;
      if (got[base + i].d !== {112'h0, 16'(16'h0100 + i)} || got[base + i].gs !== (i == 0)) begin
        fails++;
        $display("FAIL bp_set%0d: got %h want d0=%h gs=%b", i, got[base + i],
                 16'(16'h0100 + i), (i == 0));
      end
    end
    for (int i = 1; i < 16 && i < got_cnt - base; i++) begin
      asserts++;
      if (got_cyc[base + i] - got_cyc[base + i - 1] != 2) begin
        fails++;
        $display("FAIL bp_gap%0d: got %0d cycles want 2", i,
                 got_cyc[base + i] - got_cyc[base + i - 1]);
      end
    end
    asserts++;
    if (stab_viol != sv0) begin
      fails++;
      $display("FAIL bp_stable: got %0d dout changes under stall want 0", stab_viol - sv0);
    end
    exp_total += 16;
    asserts++;
    if (set_count !== 16'(exp_total)) begin
      fails++;
      $display("FAIL bp_set_count: got %0d want %0d", set_count, 16'(exp_total));
    end
  endtask

  task automatic test_sync_error();
    int base;
    base = got_cnt;
    push(TAG);
    for (int k = 0; k < 5; k++) push(16'(16'h0200 + k));
    channels = 4'd8;
    out_ready = 1'b1;
    enable = 1'b1;
    tick(15);
    enable = 1'b0;
    tick(2);
    asserts++;
    if (sync_error !== 1'b1 || got_cnt != base) begin
      fails++;
      $display("FAIL sync_abort: got err=%b sets=%0d want 1/0", sync_error, got_cnt - base);
    end
    clear_status = 1'b1;
    tick(1);
    clear_status = 1'b0;
    asserts++;
    if (sync_error !== 1'b0) begin
      fails++;
      $display("FAIL sync_clear: got %b want 0", sync_error);
    end
    // Abort and clear land on the same edge: the new error must survive.
    push(TAG);
    for (int k = 0; k < 3; k++) push(16'(16'h0300 + k));
    enable = 1'b1;
    tick(12);
    enable = 1'b0;
    clear_status = 1'b1;
    tick(1);
    clear_status = 1'b0;
    asserts++;
    if (sync_error !== 1'b1) begin
      fails++;
      $display("FAIL sync_set_wins: got %b want 1", sync_error);
    end
    clear_status = 1'b1;
    tick(1);
    clear_status = 1'b0;
    asserts++;
    if (sync_error !== 1'b0 || got_cnt != base) begin
      fails++;
      $display("FAIL sync_final: got err=%b sets=%0d want 0/0", sync_error, got_cnt - base);
    end
  endtask

  task automatic test_random();
    logic [15:0] w [$];
    int b;
    for (int r = 0; r < 4; r++) begin
      w.delete();
      for (int k = 0; k < int'($urandom_range(2)); k++) w.push_back(16'($urandom));
      w.push_back(TAG);
      for (int k = 0; k < int'($urandom_range(40, 10)); k++)
        w.push_back(($urandom_range(9) == 0) ? TAG : 16'($urandom));
      test_stream($sformatf("random%0d", r), int'($urandom_range(15)), w,
                  int'($urandom_range(100, 30)), b);
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] v [9] = '{16'h4000, 16'h0a01, 16'h0a02, 16'h0a03, 16'h0b01, 16'h0b02,
                           16'h4000, 16'h0c01, 16'h0c02};
    int base;
    bit ok;
    foreach (v[k]) push(v[k]);
    channels = 4'd2;
    out_ready = 1'b0;
    enable = 1'b1;
    for (int k = 0; k < 50 && !out_valid; k++) tick(1);
    asserts++;
    if (out_valid !== 1'b1) begin
      fails++;
      $display("FAIL rstmid_valid: out_valid got %b want 1", out_valid);
    end
    #2 reset = 1'b1;
    #1;
    asserts++;
    if ({out_valid, fifo_rdreq, gate_start, sync_error} !== 4'b0 || set_count !== 16'd0) begin
      fails++;
      $display("FAIL rstmid_ctl: got v=%b rd=%b gs=%b err=%b cnt=%0d want all 0",
               out_valid, fifo_rdreq, gate_start, sync_error, set_count);
    end
    for (int i = 0; i < 8; i++) begin
      asserts++;
      if (dout[i] !== 16'h0) begin
        fails++;
        $display("FAIL rstmid_dout%0d: got %h want 0000", i, dout[i]);
      end
    end
    @(posedge clk);
    #1 reset = 1'b0;
    exp_total = 0;
    base = got_cnt;
    drain(100, ok);
    enable = 1'b0;
    tick(2);
    asserts++;
    if (!ok || got_cnt - base != 1) begin
      fails++;
      $display("FAIL rstmid_count: got %0d sets (drained=%b) want 1", got_cnt - base, ok);
    end
    asserts++;
    if (got[base].d !== {96'h0, 32'h0c02_0c01} || got[base].gs !== 1'b1) begin
      fails++;
      $display("FAIL rstmid_set: got %h want gs=1 0c02_0c01", got[base]);
    end
    asserts++;
    if (set_count !== 16'd1) begin
      fails++;
      $display("FAIL rstmid_set_count: got %0d want 1", set_count);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hunt_junk();
    test_tag_as_data();
    test_backpressure();
    test_sync_error();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
